// File: rtl/multicycle_control_hs.sv
// rtl/multicycle_control_hs.sv - multicycle CPU control FSM with memory handshake, timeout and illegal-opcode detection
//
// Ports:
//   clock, reset (async active-low)
//   opcode      instruction opcode, sampled only in DECODE
//   mem_ready   memory accepts/completes the current request
//   mem_req     memory request, held until mem_ready
//   PCWriteCond, PCWrite, MemWrite, MemtoReg, IRWrite, RegWrite, Instr26, RegSelect1
//   PCSource, ALUOp, ALUSrcA, ALUSrcB, RegSelect2   datapath selects
//   state       current state code
//   instr_done  one-cycle retire pulse
//   ill_op      one-cycle pulse in DECODE on an unknown opcode
//   err         sticky memory-timeout error
//   retired     retired-instruction count
// Optional: PERF_CNT_EN enables the retired counter; otherwise retired is 0.
module multicycle_control_hs #(
  parameter int OPW      = 6,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [OPW-1:0]   opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PCWriteCond,
  output logic             PCWrite,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             Instr26,
  output logic             RegSelect1,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       RegSelect2,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             ill_op,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_BRANCH   = 4'd3,
    S_JUMP     = 4'd4,
    S_EXEC_R   = 4'd5,
    S_EXEC_I   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_MEM_ADDR = 4'd8,
    S_MEM_RD   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_WB_MEM   = 4'd11,
    S_ERROR    = 4'd15
  } state_t;

  localparam logic [5:0] OP_NOOP = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b010101;
  localparam logic [5:0] OP_BEQ  = 6'b100000;
  localparam logic [5:0] OP_BNE  = 6'b100001;
  localparam logic [5:0] OP_BLT  = 6'b100010;
  localparam logic [5:0] OP_ADDI = 6'b110010;
  localparam logic [5:0] OP_LUI  = 6'b111010;
  localparam logic [5:0] OP_LWI  = 6'b111011;
  localparam logic [5:0] OP_SWI  = 6'b111100;
  localparam logic [5:0] OP_LW   = 6'b111101;
  localparam logic [5:0] OP_SW   = 6'b111110;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state_q, state_d;
  logic [5:0] op_q;    // opcode captured in DECODE for the later states
  logic [7:0] wait_q, wait_d;
  logic       hi_nz;

  // Any set bit above the decoded field makes the opcode illegal.
  assign hi_nz = (opcode >> 6) != '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_DECODE) op_q <= opcode[5:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    Instr26     = 1'b0;
    RegSelect1  = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    RegSelect2  = 2'b00;
    instr_done  = 1'b0;
    ill_op      = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        state_d = S_FETCH;
        if (hi_nz) begin
          ill_op = 1'b1;
        end else begin
          case (opcode[5:0])
            OP_NOOP:                        instr_done = 1'b1;
            OP_J:                           state_d = S_JUMP;
            OP_AND:                         state_d = S_EXEC_R;
            OP_BEQ, OP_BNE, OP_BLT:         state_d = S_BRANCH;
            OP_ADDI, OP_LUI:                state_d = S_EXEC_I;
            OP_LW, OP_SW, OP_LWI, OP_SWI:   state_d = S_MEM_ADDR;
            default:                        ill_op = 1'b1;
          endcase
        end
      end
      S_BRANCH: begin
        ALUSrcA     = 2'b01;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        Instr26    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        ALUSrcA = (op_q == OP_LUI) ? 2'b10 : 2'b01;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        state_d = S_WB_ALU;
      end
      S_WB_ALU: begin
        RegWrite   = 1'b1;
        RegSelect2 = (op_q == OP_AND) ? 2'b00 : 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcB = 2'b10;
        if (op_q == OP_LWI || op_q == OP_SWI) begin
          ALUSrcA    = 2'b10;
          RegSelect1 = 1'b1;
        end else begin
          ALUSrcA = 2'b01;
        end
        state_d = (op_q == OP_LW || op_q == OP_LWI) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_WB_MEM: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        RegSelect2 = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
    // This un-acked cycle would bring the count to MAX_WAIT; an ack on it wins.
    if (mem_req && !mem_ready && wait_q == WAIT_LAST) state_d = S_ERROR;
  end

  always_comb begin
    wait_d = wait_q;
    if (mem_ready || state_d != state_q) wait_d = '0;
    else if (mem_req)                    wait_d = wait_q + 8'd1;
  end

  assign state = state_q;
  assign err   = (state_q == S_ERROR);

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] ret_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          ret_q <= '0;
    else if (instr_done) ret_q <= ret_q + 1'b1;
  end
  assign retired = ret_q;
`else
  assign retired = '0;
`endif

endmodule

// File: doc/multicycle_control_hs.md
Name: multicycle_control_hs

Overview:
- Parametrised successor to the multicycle CPU control FSM.
- Drives the same datapath control bus, plus a memory request/ready handshake with wait states, a memory timeout with a sticky error, and illegal-opcode detection.
- Sits between instruction register opcode field, datapath muxes/ALU and the unified instruction/data memory.

Parameters:
- OPW, 6: opcode width; bits [5:0] decoded; any nonzero bit above 5 marks the opcode illegal.
- MAX_WAIT, 15: consecutive un-acked request cycles before timeout, 1..255.
- CNT_W, 16: retired-instruction counter width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  OPW  instruction opcode, sampled in DECODE
- mem_ready  in  1  memory accepts/completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- PCWriteCond, PCWrite, MemWrite, MemtoReg, IRWrite, RegWrite, Instr26, RegSelect1  out  1 each  datapath controls
- PCSource, ALUOp, ALUSrcA, ALUSrcB, RegSelect2  out  2 each  datapath mux/ALU selects
- state  out  4  current state code
- instr_done  out  1  one-cycle pulse, instruction retired
- ill_op  out  1  one-cycle pulse in DECODE on an unknown opcode
- err  out  1  sticky timeout error
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset low (async): state=RESET(0); every output 0; wait counter and retired are 0. The first clock edge after release enters FETCH.
- Opcodes: NOOP 000000, J 000001, AND 010101, BEQ 100000, BNE 100001, BLT 100010, ADDI 110010, LUI 111010, LWI 111011, SWI 111100, LW 111101, SW 111110.
- Outputs are Moore on state. Exception: IRWrite and PCWrite in FETCH are gated by mem_ready. Any control not listed for a state is 0.
- FETCH(1):
  - Drives mem_req=1, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=00.
  - On mem_ready, IRWrite=PCWrite=1 and the next state is DECODE; otherwise the FSM stays in FETCH.
- DECODE(2):
  - Drives ALUSrcB=11, ALUOp=00.
  - Next state: BEQ/BNE/BLT go to BRANCH; J to JUMP; AND to EXEC_R; ADDI/LUI to EXEC_I; LW/SW/LWI/SWI to MEM_ADDR.
  - NOOP goes to FETCH with instr_done=1.
  - An illegal opcode goes to FETCH with ill_op=1 and instr_done=0.
- BRANCH(3): ALUSrcA=01, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1; next FETCH.
- JUMP(4): PCWrite=1, PCSource=10, Instr26=1, instr_done=1; next FETCH.
- EXEC_R(5): ALUSrcA=01, ALUSrcB=00, ALUOp=10; next WB_ALU.
- EXEC_I(6): ALUSrcA=01 for ADDI or 10 for LUI, ALUSrcB=10, ALUOp=11; next WB_ALU.
- WB_ALU(7): RegWrite=1, RegSelect2=00 for AND or 01 for I-type, instr_done=1; next FETCH.
- MEM_ADDR(8):
  - Drives ALUSrcB=10, ALUOp=00.
  - LW/SW use ALUSrcA=01. LWI/SWI use ALUSrcA=10 with RegSelect1=1.
  - Next state: loads go to MEM_RD, stores to MEM_WR.
- MEM_RD(9): mem_req=1; stays until mem_ready, then goes to WB_MEM.
- MEM_WR(10): mem_req=1, MemWrite=1; stays until mem_ready, then goes to FETCH with instr_done=1 on the acking cycle.
- WB_MEM(11): RegWrite=1, MemtoReg=1, RegSelect2=01, instr_done=1; next FETCH.
- ERROR(15): every control 0, err=1. The FSM leaves ERROR only through reset.
- Latency with mem_ready always 1:
  - NOOP 2 cycles.
  - J and branches 3 cycles.
  - AND, ADDI, LUI, SW, SWI 4 cycles.
  - LW and LWI 5 cycles.
- Wait counter:
  - Increments each cycle that mem_req=1 and mem_ready=0.
  - Clears on mem_ready and on every state change.
  - When it reaches MAX_WAIT with mem_ready still 0, the next state is ERROR.
  - If mem_ready arrives on the same cycle the count reaches MAX_WAIT, the acknowledge wins.
- opcode is only sampled in DECODE; changes in other states are ignored.
- Reset asserted mid-instruction aborts it: state returns to RESET, no instr_done, retired is cleared.

Optional Feature:
- PERF_CNT_EN defined: retired increments on every instr_done and wraps from 2^CNT_W-1 to 0.
- PERF_CNT_EN undefined: retired is tied to 0; no counter flops are inferred.

Test Plan:
- Reset low 100 ns, mem_ready=1, opcode=000001 (J) -> state sequence 1,2,4,1; PCWrite=1 and PCSource=10 in JUMP; instr_done pulses once.
- LW 111101 with mem_ready held 0 for 3 cycles in MEM_RD -> MEM_RD lasts 4 cycles; then WB_MEM has RegWrite=1, MemtoReg=1; no err.
- SW 111110 with mem_ready=0 permanently, MAX_WAIT=15 -> after 15 cycles state=15, err=1, all controls 0; state stays 15 until reset.
- Opcode 101010 (illegal) -> state 1,2,1; ill_op=1 for one cycle; instr_done=0; retired unchanged.
- PERF_CNT_EN defined, CNT_W=4, 17 back-to-back NOOPs -> retired=1 (wrapped); build without PERF_CNT_EN -> retired=0.
- Pull reset low while in EXEC_I (ADDI) -> all outputs 0 immediately, without waiting for a clock edge; after release the FSM restarts at FETCH.
